// File: rtl/cla_seq_adder_ctrl_pkg.sv
// cla_seq_adder_ctrl_pkg: slice width and FSM state encodings shared by the sequential CLA adder
package cla_seq_adder_ctrl_pkg;
   localparam int SLICE = 4;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// carry_look_ahead_4: 4-bit carry look-ahead slice; c[k] is the carry out of bit k
module carry_look_ahead_4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       c_in,
   output logic [3:0] c,
   output logic       c_out,
   output logic       p_out,
   output logic       g_out
);
   assign c[0]  = g[0] | (p[0] & c_in);
   assign c[1]  = g[1] | (p[1] & g[0]) | (&p[1:0] & c_in);
   assign c[2]  = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c_in);
   assign p_out = &p;
   assign g_out = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
   assign c[3]  = g_out | (p_out & c_in);
   assign c_out = c[3];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: time-multiplexes one 4-bit CLA slice across a WIDTH-bit add,
// one slice per clock, least-significant slice first, with a one-cycle done pulse
module cla_seq_adder_ctrl
   import cla_seq_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             p_out,
   output logic             g_out,
   output logic             ovf
);
   localparam int N  = WIDTH / SLICE;
   localparam int IW = $clog2(N);
   logic [1:0]       r_state;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_carry, r_pacc, r_gacc;
   logic [SLICE-1:0] w_p, w_g, w_c, w_sum;
   logic             w_cout, w_sp, w_sg, w_last, w_pacc, w_gacc;
   assign w_p    = r_a[r_idx*SLICE +: SLICE] ^ r_b[r_idx*SLICE +: SLICE];
   assign w_g    = r_a[r_idx*SLICE +: SLICE] & r_b[r_idx*SLICE +: SLICE];
   assign w_sum  = w_p ^ {w_c[SLICE-2:0], r_carry};
   assign w_last = r_idx == IW'(N - 1);
   // accumulated group terms treat each new slice as the more significant half
   assign w_pacc = r_pacc & w_sp;
   assign w_gacc = w_sg | (w_sp & r_gacc);
   assign busy   = r_state == S_RUN;
   assign done   = r_state == S_DONE;
   carry_look_ahead_4 u_cla (
      .p(w_p), .g(w_g), .c_in(r_carry), .c(w_c), .c_out(w_cout), .p_out(w_sp), .g_out(w_sg)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_pacc  <= 1'b0;
         r_gacc  <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
         p_out   <= 1'b0;
         g_out   <= 1'b0;
         ovf     <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_pacc  <= 1'b1;
            r_gacc  <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            p_out   <= 1'b0;
            g_out   <= 1'b0;
            ovf     <= 1'b0;
            r_state <= S_RUN;
         end
      end else if (r_state == S_RUN) begin
         sum[r_idx*SLICE +: SLICE] <= w_sum;
         r_carry <= w_cout;
         r_pacc  <= w_pacc;
         r_gacc  <= w_gacc;
         if (w_last) begin
            c_out   <= w_cout;
            ovf     <= w_c[SLICE-2] ^ w_c[SLICE-1];
            p_out   <= w_pacc;
            g_out   <= w_gacc;
            r_state <= S_DONE;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: directed and random checks of the sequential CLA adder
module tb_cla_seq_adder_ctrl;
   logic        clk, rst, start, c_in;
   logic [15:0] a, b, sum;
   logic        busy, done, c_out, p_out, g_out, ovf;
   int          checks = 0;
   int          errors = 0;

   cla_seq_adder_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy), .done(done), .sum(sum), .c_out(c_out), .p_out(p_out), .g_out(g_out), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sum, c_out, p_out, g_out, ovf} from plain integer arithmetic
   function automatic logic [19:0] ref_out(input logic [15:0] x, input logic [15:0] y, input logic ci);
      logic [16:0] t, u;
      t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      u = {1'b0, x} + {1'b0, y};
      return {t[15:0], t[16], &(x ^ y), u[16], (x[15] == y[15]) && (t[15] != x[15])};
   endfunction

   function automatic logic [19:0] obs();
      return {sum, c_out, p_out, g_out, ovf};
   endfunction

   // called in IDLE at posedge+1; returns at posedge+1 one cycle after the done cycle
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci, output int lat);
      start = 1'b1; a = x; b = y; c_in = ci;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, obs()} !== 22'd0) begin
         $display("FAIL reset_outputs got %h exp %h", {busy, done, obs()}, 22'd0);
         errors++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL reset_idle got %b exp %b", {busy, done}, 2'b00);
         errors++;
      end
   endtask

   task automatic test_ripple();
      int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 4) begin
         $display("FAIL ripple_latency got %0d exp %0d", lat, 4);
         errors++;
      end
      checks++;
      if (obs() !== 20'h0000A) begin
         $display("FAIL ripple_result got %h exp %h", obs(), 20'h0000A);
         errors++;
      end
      checks++;
      if (done !== 1'b0) begin
         $display("FAIL ripple_done_width got %b exp %b", done, 1'b0);
         errors++;
      end
   endtask

   task automatic test_propagate();
      int lat;
      run_op(16'hAAAA, 16'h5555, 1'b0, lat);
      checks++;
      if (obs() !== 20'hFFFF4) begin
         $display("FAIL propagate_cin0 got %h exp %h", obs(), 20'hFFFF4);
         errors++;
      end
      run_op(16'hAAAA, 16'h5555, 1'b1, lat);
      checks++;
      if (obs() !== 20'h0000C) begin
         $display("FAIL propagate_cin1 got %h exp %h", obs(), 20'h0000C);
         errors++;
      end
   endtask

   task automatic test_overflow();
      int lat;
      run_op(16'h7FFF, 16'h0001, 1'b0, lat);
      checks++;
      if (obs() !== 20'h80001) begin
         $display("FAIL overflow_pos got %h exp %h", obs(), 20'h80001);
         errors++;
      end
      run_op(16'h8000, 16'h8000, 1'b0, lat);
      checks++;
      if (obs() !== 20'h0000B) begin
         $display("FAIL overflow_neg got %h exp %h", obs(), 20'h0000B);
         errors++;
      end
   endtask

   task automatic test_hold();
      int pulses = 0;
      start = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b1;
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      start = 1'b0;
      checks++;
      if (pulses !== 1) begin
         $display("FAIL hold_done_pulses got %0d exp %0d", pulses, 1);
         errors++;
      end
      checks++;
      if (obs() !== 20'h55560) begin
         $display("FAIL hold_result got %h exp %h", obs(), 20'h55560);
         errors++;
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, done, obs()} !== {2'b00, 20'h55560}) begin
            $display("FAIL hold_idle_%0d got %h exp %h", k, {busy, done, obs()}, {2'b00, 20'h55560});
            errors++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      start = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, obs()} !== 22'd0) begin
         $display("FAIL reset_mid_outputs got %h exp %h", {busy, done, obs()}, 22'd0);
         errors++;
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, done} !== 2'b00) begin
            $display("FAIL reset_mid_quiet_%0d got %b exp %b", k, {busy, done}, 2'b00);
            errors++;
         end
      end
      run_op(16'h0003, 16'h0004, 1'b0, lat);
      checks++;
      if (obs() !== 20'h00070) begin
         $display("FAIL reset_mid_after got %h exp %h", obs(), 20'h00070);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ca, cb;
      logic        cc;
      int          cnt;
      ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
      start = 1'b1; a = ca; b = cb; c_in = cc;
      for (int i = 0; i < 200; i++) begin
         cnt = 0;
         do begin
            @(posedge clk); #1;
            cnt++;
         end while (done !== 1'b1 && cnt < 20);
         checks++;
         if (cnt !== (i == 0 ? 5 : 6)) begin
            $display("FAIL b2b_spacing_%0d got %0d exp %0d", i, cnt, i == 0 ? 5 : 6);
            errors++;
         end
         checks++;
         if (obs() !== ref_out(ca, cb, cc)) begin
            $display("FAIL b2b_result_%0d a=%h b=%h cin=%b got %h exp %h", i, ca, cb, cc, obs(), ref_out(ca, cb, cc));
            errors++;
         end
         ca = 16'($urandom); cb = 16'($urandom); cc = 1'($urandom);
         a = ca; b = cb; c_in = cc;
      end
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_ripple();
      test_propagate();
      test_overflow();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
